// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the shift_deser serial-to-parallel receiver.
package shift_deser_pkg;

  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;

  // Value that XOR of all data bits and the parity bit must give (even parity)
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/deser_outbuf.sv
// One-entry valid/ready holding register for received words, with sticky overrun.
module deser_outbuf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  input  logic         ovr_clr,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         overrun
);

  logic take_c;
  logic drop_c;

  assign take_c = valid & ready;
  // A completed word is dropped only if the buffer stays occupied across this edge
  assign drop_c = load & valid & ~ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load && !drop_c) begin
        q     <= d;
        valid <= 1'b1;
      end else if (take_c) begin
        valid <= 1'b0;
      end

      if (drop_c) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_deser.sv
// LSB-first serial-to-parallel deserializer feeding a one-entry valid/ready buffer.
// Optional even-parity bit after each word when SHIFT_DESER_PARITY_EN is defined.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_in,
  input  logic         s_en,
  input  logic         s_start,
  output logic [N-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         busy,
  output logic         overrun,
  input  logic         ovr_clr,
  output logic         parity_err
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   sh;
  logic [N-1:0]   sh_nxt;
  logic [N-1:0]   sh_shift;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [N-1:0]   word_c;
  logic           done_c;
  logic           perr_c;

  assign sh_shift = {s_in, sh[N-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    word_c    = sh;
    done_c    = 1'b0;
    perr_c    = 1'b0;
    case (state)
      IDLE: begin
        if (s_en && s_start) begin
          sh_nxt    = {s_in, {(N - 1){1'b0}}};
          cnt_nxt   = CW'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (s_en && s_start) begin
          // Restart: drop the partial frame, current bit becomes bit 0
          sh_nxt  = {s_in, {(N - 1){1'b0}}};
          cnt_nxt = CW'(1);
        end else if (s_en) begin
          sh_nxt = sh_shift;
          if (cnt == LAST_IDX) begin
`ifdef SHIFT_DESER_PARITY_EN
            cnt_nxt   = CW'(N);
            state_nxt = PAR;
`else
            word_c    = sh_shift;
            done_c    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
`ifdef SHIFT_DESER_PARITY_EN
      PAR: begin
        if (s_en && s_start) begin
          sh_nxt    = {s_in, {(N - 1){1'b0}}};
          cnt_nxt   = CW'(1);
          state_nxt = RECV;
        end else if (s_en) begin
          word_c    = sh;
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if ((^sh ^ s_in) == PARITY_EVEN) begin
            done_c = 1'b1;
          end else begin
            perr_c = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef SHIFT_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_c;
    end
  end
`else
  logic unused_perr;
  assign unused_perr = perr_c;
  assign parity_err  = 1'b0;
`endif

  deser_outbuf #(
    .W(N)
  ) u_outbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (done_c),
    .d       (word_c),
    .ready   (q_ready),
    .ovr_clr (ovr_clr),
    .q       (q),
    .valid   (q_valid),
    .overrun (overrun)
  );

endmodule
